// File: rtl/fsm_seq_driver.sv
// Plays a stored (a,b) vector sequence into the segment FSM and scores its (y0,yl) replies.
// Latency: len+LAT+2 cycles from start to done (1 cycle when len=0); no backpressure, start ignored while busy.
module fsm_seq_driver #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LAT   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [1:0]    load_ab,
  input  logic [1:0]    load_exp,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          y0,
  input  logic          yl,
  output logic          a,
  output logic          b,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] idx;
  logic [AW:0]   len_r;
  logic [AW:0]   len_c;
  logic [AW:0]   nxt;
  logic [2:0]    dcnt;
  logic [3:0]    ent0;
  logic [3:0]    entn;
  logic          mism;

  // Expected value and index travel alongside the FSM response so the
  // comparison lines up with the sample taken LAT+1 edges after the drive.
  logic          pv [LAT+1];
  logic [1:0]    pe [LAT+1];
  logic [AW-1:0] pi [LAT+1];

  assign len_c = (len > DEPTH_W) ? DEPTH_W : len;
  assign nxt   = {1'b0, idx} + (AW+1)'(1);
  assign ent0  = mem[0];
  assign entn  = mem[nxt[AW-1:0]];
  assign mism  = pv[LAT] && (pe[LAT] != {y0, yl});
  assign pass  = (err_count == '0);

  always_ff @(posedge clk) begin
    if (load_en && state == IDLE) begin
      mem[load_addr] <= {load_ab, load_exp};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      len_r     <= '0;
      dcnt      <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      first_err <= '1;
      for (int k = 0; k <= LAT; k++) begin
        pv[k] <= 1'b0;
        pe[k] <= '0;
        pi[k] <= '0;
      end
    end else begin
      done  <= 1'b0;
      pv[0] <= 1'b0;
      for (int k = LAT; k > 0; k--) begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        pi[k] <= pi[k-1];
      end

      if (mism) begin
        err_count <= err_count + (AW+1)'(1);
        if (&first_err) begin
          first_err <= pi[LAT];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            err_count <= '0;
            first_err <= '1;
            idx       <= '0;
            len_r     <= len_c;
            if (len_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= RUN;
              busy   <= 1'b1;
              {a, b} <= ent0[3:2];
              pv[0]  <= 1'b1;
              pe[0]  <= ent0[1:0];
              pi[0]  <= '0;
            end
          end
        end
        RUN: begin
          if (nxt == len_r) begin
            state <= DRAIN;
            a     <= 1'b0;
            b     <= 1'b0;
            dcnt  <= '0;
          end else begin
            idx    <= nxt[AW-1:0];
            {a, b} <= entn[3:2];
            pv[0]  <= 1'b1;
            pe[0]  <= entn[1:0];
            pi[0]  <= nxt[AW-1:0];
          end
        end
        DRAIN: begin
          // Last compare lands at dcnt == LAT-1; one more cycle makes results final.
          if (dcnt == 3'(LAT)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Self-checking bench: three drivers (LAT 1, 2, 4), each driving its own behavioural segment FSM plant.
// Table vectors for LAT=1, a sequence-level reference model for all instances, plus hand-written corner cases.
module tb_fsm_seq_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [1:0] load_ab = '0;
  logic [1:0] load_exp = '0;
  logic       start = 1'b0;
  logic [4:0] len = '0;

  logic       a_o [3];
  logic       b_o [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       pass_o [3];
  logic [4:0] err_o [3];
  logic [3:0] first_o [3];
  logic [1:0] yv [3];

  int lat_of [3] = '{1, 2, 4};
  int dk [3]     = '{0, 1, 3};

  logic [1:0] mab [16]  = '{default: 2'b00};
  logic [1:0] mexp [16] = '{default: 2'b00};
  logic [1:0] st [3]    = '{default: 2'b00};
  logic [1:0] dl [3][5] = '{default: '{default: 2'b00}};

  int n_chk = 0;
  int n_fail = 0;
  int last_err [3];
  int last_first [3];
  int last_pass [3];
  int last_cyc [3];

  typedef struct {
    int         len;
    logic [3:0] flip;
    int         err;
    int         first;
    int         pass;
    int         cyc;
  } vec_t;
  vec_t tbl [5];

  logic [1:0] base_ab [4]  = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic [1:0] base_exp [4] = '{2'b00, 2'b10, 2'b11, 2'b10};

  always #5 clk = ~clk;

  fsm_seq_driver #(.DEPTH(16), .AW(4), .LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_ab(load_ab),
    .load_exp(load_exp), .start(start), .len(len), .y0(yv[0][1]), .yl(yv[0][0]),
    .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(err_o[0]), .first_err(first_o[0]));

  fsm_seq_driver #(.DEPTH(16), .AW(4), .LAT(2)) u_l2 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_ab(load_ab),
    .load_exp(load_exp), .start(start), .len(len), .y0(yv[1][1]), .yl(yv[1][0]),
    .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(err_o[1]), .first_err(first_o[1]));

  fsm_seq_driver #(.DEPTH(16), .AW(4), .LAT(4)) u_l4 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_ab(load_ab),
    .load_exp(load_exp), .start(start), .len(len), .y0(yv[2][1]), .yl(yv[2][0]),
    .a(a_o[2]), .b(b_o[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .err_count(err_o[2]), .first_err(first_o[2]));

  // Segment FSM plant: input 00 returns to state 0, otherwise state advances by ab (mod 4).
  function automatic logic [1:0] plant_next(input logic [1:0] s, input logic [1:0] ab);
    return (ab == 2'b00) ? 2'b00 : s + ab;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      st[k]    <= plant_next(st[k], {a_o[k], b_o[k]});
      dl[k][0] <= st[k];
      for (int j = 1; j < 5; j++) dl[k][j] <= dl[k][j-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      yv[k] = st[k];
      if (dk[k] > 0) yv[k] = dl[k][dk[k]-1];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int ad, input logic [1:0] ab, input logic [1:0] e);
    load_en   = 1'b1;
    load_addr = 4'(ad);
    load_ab   = ab;
    load_exp  = e;
    @(posedge clk);
    #1 load_en = 1'b0;
    mab[ad]  = ab;
    mexp[ad] = e;
  endtask

  // Sequence-level expectation: plant state after each vector, sampled with the
  // driver's latency and the plant's extra output delay.
  function automatic void predict(input int lc, input int lat, input int d,
                                  output int err, output int first);
    int s [18];
    s[0] = 0;
    for (int i = 0; i < lc; i++)
      s[i+1] = (mab[i] == 2'b00) ? 0 : (s[i] + int'(mab[i])) % 4;
    err = 0;
    first = 15;
    for (int i = 0; i < lc; i++) begin
      if (s[i+lat-d] != int'(mexp[i])) begin
        if (err == 0) first = i;
        err++;
      end
    end
  endfunction

  task automatic fill_rand(input int n, input int bad, input bit nz);
    int s;
    logic [1:0] ab, e;
    s = 0;
    for (int i = 0; i < n; i++) begin
      ab = nz ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      s  = (ab == 2'b00) ? 0 : (s + int'(ab)) % 4;
      e  = 2'(s);
      if (bad > 0 && $urandom_range(0, bad - 1) == 0) e = 2'($urandom_range(0, 3));
      load(i, ab, e);
    end
  endtask

  task automatic do_run(input int l, input bit abuse);
    int lc;
    int ecyc [3];
    int eerr [3];
    int efirst [3];
    int npulse [3];
    bit tr_ok [3];
    logic [1:0] eab;
    lc = (l > 16) ? 16 : l;
    for (int k = 0; k < 3; k++) begin
      predict(lc, lat_of[k], dk[k], eerr[k], efirst[k]);
      ecyc[k] = (lc == 0) ? 1 : lc + lat_of[k] + 2;
      last_cyc[k] = 0;
      npulse[k] = 0;
      tr_ok[k] = 1'b1;
    end
    len = 5'(l);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (abuse && c == 3) begin
        start = 1'b1; load_en = 1'b1; load_addr = 4'd1;
        load_ab = ~mab[1]; load_exp = ~mexp[1];
      end
      if (abuse && c == 4) begin
        start = 1'b0; load_en = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        eab = 2'b00;
        if (c - 1 < lc) eab = mab[c-1];
        if ({a_o[k], b_o[k]} != eab) tr_ok[k] = 1'b0;
        if (busy_o[k] != (lc > 0 && c <= lc + lat_of[k] + 1)) tr_ok[k] = 1'b0;
        if (done_o[k]) begin
          npulse[k]++;
          if (last_cyc[k] == 0) begin
            last_cyc[k]   = c;
            last_err[k]   = int'(err_o[k]);
            last_first[k] = int'(first_o[k]);
            last_pass[k]  = int'(pass_o[k]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lat%0d_len%0d_trace_ok", lat_of[k], l), int'(tr_ok[k]), 1);
      chk($sformatf("lat%0d_len%0d_done_cycle", lat_of[k], l), last_cyc[k], ecyc[k]);
      chk($sformatf("lat%0d_len%0d_done_pulses", lat_of[k], l), npulse[k], 1);
      chk($sformatf("lat%0d_len%0d_err_count", lat_of[k], l), last_err[k], eerr[k]);
      chk($sformatf("lat%0d_len%0d_first_err", lat_of[k], l), last_first[k], efirst[k]);
      chk($sformatf("lat%0d_len%0d_pass", lat_of[k], l), last_pass[k], (eerr[k] == 0) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    tbl[0] = '{4, 4'b0000, 0, 15, 1, 7};
    tbl[1] = '{4, 4'b1010, 2, 1, 0, 7};
    tbl[2] = '{0, 4'b1111, 0, 15, 1, 1};
    tbl[3] = '{2, 4'b1000, 0, 15, 1, 5};
    tbl[4] = '{3, 4'b0100, 1, 2, 0, 6};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ab", int'({a_o[0], b_o[0]}), 0);
    chk("reset_busy", int'(busy_o[0]), 0);
    chk("reset_done", int'(done_o[0]), 0);
    chk("reset_pass", int'(pass_o[0]), 1);
    chk("reset_err_count", int'(err_o[0]), 0);
    chk("reset_first_err", int'(first_o[0]), 15);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++)
        load(i, base_ab[i], base_exp[i] ^ (tbl[r].flip[i] ? 2'b01 : 2'b00));
      do_run(tbl[r].len, 1'b0);
      chk($sformatf("tbl%0d_err_count", r), last_err[0], tbl[r].err);
      chk($sformatf("tbl%0d_first_err", r), last_first[0], tbl[r].first);
      chk($sformatf("tbl%0d_pass", r), last_pass[0], tbl[r].pass);
      chk($sformatf("tbl%0d_done_cycle", r), last_cyc[0], tbl[r].cyc);
    end

    // Plant delayed one cycle too long for the LAT=2 driver.
    for (int i = 0; i < 4; i++) load(i, base_ab[i], base_exp[i]);
    dk[1] = 2;
    do_run(4, 1'b0);
    chk("lat2_delay_skew_errs_nonzero", int'(last_err[1] > 0), 1);
    dk[1] = 1;

    fill_rand(16, 0, 1'b0);
    do_run(20, 1'b0);
    chk("len20_clamp_cycles", last_cyc[0], 19);
    chk("len20_clamp_pass", last_pass[0], 1);

    fill_rand(8, 3, 1'b0);
    do_run(8, 1'b1);
    do_run(8, 1'b0);

    // Reset in the middle of a run; entry 0 is wrong so an error is pending.
    fill_rand(8, 0, 1'b1);
    load(0, mab[0], ~mexp[0]);
    len = 5'd8;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrun_busy_before", int'(busy_o[0]), 1);
    chk("midrun_err_before", int'(err_o[0]), 1);
    reset = 1'b0;
    #1;
    chk("midrun_reset_ab", int'({a_o[0], b_o[0]}), 0);
    chk("midrun_reset_busy", int'(busy_o[0]), 0);
    chk("midrun_reset_done", int'(done_o[0]), 0);
    chk("midrun_reset_err", int'(err_o[0]), 0);
    chk("midrun_reset_first", int'(first_o[0]), 15);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    do_run(8, 1'b0);

    for (int r = 0; r < 10; r++) begin
      fill_rand(16, 4, 1'b0);
      do_run(int'($urandom_range(0, 20)), 1'b0);
    end

    // Start held high re-arms immediately after DONE.
    fill_rand(8, 0, 1'b0);
    len = 5'd8;
    start = 1'b1;
    t = 0;
    while (!done_o[0] && t < 60) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done_o[0] && t < 60);
    chk("held_start_done_gap", t, 12);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("held_start_settled_idle", int'(busy_o[0] | busy_o[1] | busy_o[2]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
